// File: rtl/dso_pkg.sv
// Shared constants for the DSO host-command dispatcher: opcodes, response codes,
// the pot write prefix and the dispatcher FSM state encoding.
package dso_pkg;

   localparam logic [7:0] OP_SET_GAIN   = 8'h02;
   localparam logic [7:0] OP_SET_TRIG   = 8'h03;
   localparam logic [7:0] OP_GET_GAIN   = 8'h05;
   localparam logic [7:0] OP_EEP_RD     = 8'h08;

   localparam logic [7:0] RESP_ACK      = 8'hA5;
   localparam logic [7:0] RESP_NAK      = 8'hEE;

   // Upper byte of every digital-pot write word (16'h13xx)
   localparam logic [7:0] POT_WR_PREFIX = 8'h13;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      SPI_WAIT,
      RESP,
      RESP_WAIT
   } state_t;

endpackage

// File: rtl/dso_cmd_dispatch.sv
// Host-command dispatcher: decodes 24-bit commands, drives SPI to pots/EEPROM,
// keeps a per-channel gain shadow and answers the host. Optional SPI timeout: DSO_CMD_TIMEOUT_EN.
module dso_cmd_dispatch #(
   parameter int NUM_CH  = 3,
   parameter int GAIN_W  = 3,
   parameter int SS_W    = $clog2(NUM_CH + 2),
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [23:0]              cmd,
   input  logic                     cmd_rdy,
   output logic                     clr_cmd_rdy,
   output logic [15:0]              SPI_data,
   output logic                     wrt_SPI,
   output logic [SS_W-1:0]          ss,
   input  logic                     SPI_done,
   input  logic [7:0]               EEP_data,
   output logic [NUM_CH*GAIN_W-1:0] gain,
   output logic [7:0]               resp_data,
   output logic                     send_resp,
   input  logic                     resp_sent
);
   import dso_pkg::*;

   state_t                     state_reg, state_next;
   logic [23:0]                cmd_reg, cmd_next;
   logic                       clr_reg, clr_next;
   logic                       wrt_reg, wrt_next;
   logic                       send_reg, send_next;
   logic [15:0]                spi_data_reg, spi_data_next;
   logic [SS_W-1:0]            ss_reg, ss_next;
   logic [7:0]                 resp_reg, resp_next;
   logic                       gain_wr;
   logic [NUM_CH*GAIN_W-1:0]   gain_vec;
   logic [GAIN_W-1:0]          gain_rd;
   logic                       timeout;
   logic                       spi_finished;

   logic [7:0] opcode, ch;
   logic       ch_ok;
   assign opcode = cmd_reg[23:16];
   assign ch     = cmd_reg[15:8];
   assign ch_ok  = (ch != 8'd0) && (ch <= 8'(NUM_CH));

   // A done strobe coinciding with the wrt_SPI pulse belongs to nothing we started
   assign spi_finished = (state_reg == SPI_WAIT) && SPI_done && !wrt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_gain
         logic [GAIN_W-1:0] gain_reg;
         always_ff @(posedge clk) begin
            if (rst)
               gain_reg <= '0;
            else if (gain_wr && (ch == 8'(gi + 1)))
               gain_reg <= cmd_reg[GAIN_W-1:0];
         end
         assign gain_vec[gi*GAIN_W +: GAIN_W] = gain_reg;
      end
   endgenerate

   always_comb begin
      gain_rd = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch == 8'(i + 1))
            gain_rd = gain_vec[i*GAIN_W +: GAIN_W];
      end
   end

`ifdef DSO_CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || (state_reg != SPI_WAIT))
         tmo_cnt_reg <= '0;
      else
         tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
   end

   assign timeout = (state_reg == SPI_WAIT) && (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cmd_reg      <= '0;
         clr_reg      <= 1'b0;
         wrt_reg      <= 1'b0;
         send_reg     <= 1'b0;
         spi_data_reg <= '0;
         ss_reg       <= '0;
         resp_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         cmd_reg      <= cmd_next;
         clr_reg      <= clr_next;
         wrt_reg      <= wrt_next;
         send_reg     <= send_next;
         spi_data_reg <= spi_data_next;
         ss_reg       <= ss_next;
         resp_reg     <= resp_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cmd_next      = cmd_reg;
      clr_next      = 1'b0;
      wrt_next      = 1'b0;
      send_next     = 1'b0;
      spi_data_next = spi_data_reg;
      ss_next       = ss_reg;
      resp_next     = resp_reg;
      gain_wr       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (cmd_rdy) begin
               cmd_next   = cmd;
               clr_next   = 1'b1;
               state_next = DECODE;
            end
         end

         DECODE: begin
            state_next = RESP;
            resp_next  = RESP_NAK;
            case (opcode)
               OP_SET_GAIN: begin
                  if (ch_ok) begin
                     spi_data_next = {POT_WR_PREFIX, cmd_reg[7:0]};
                     ss_next       = SS_W'(ch);
                     wrt_next      = 1'b1;
                     resp_next     = resp_reg;
                     state_next    = SPI_WAIT;
                  end
               end
               OP_SET_TRIG: begin
                  spi_data_next = {POT_WR_PREFIX, cmd_reg[7:0]};
                  ss_next       = '0;
                  wrt_next      = 1'b1;
                  resp_next     = resp_reg;
                  state_next    = SPI_WAIT;
               end
               OP_GET_GAIN: begin
                  if (ch_ok)
                     resp_next = 8'(gain_rd);
               end
               OP_EEP_RD: begin
                  spi_data_next = {2'b00, ch[5:0], 8'h00};
                  ss_next       = SS_W'(NUM_CH + 1);
                  wrt_next      = 1'b1;
                  resp_next     = resp_reg;
                  state_next    = SPI_WAIT;
               end
               default: ;
            endcase
         end

         SPI_WAIT: begin
            if (spi_finished) begin
               resp_next  = (opcode == OP_EEP_RD) ? EEP_data : RESP_ACK;
               gain_wr    = (opcode == OP_SET_GAIN);
               state_next = RESP;
            end else if (timeout) begin
               resp_next  = RESP_NAK;
               state_next = RESP;
            end
         end

         RESP: begin
            send_next  = 1'b1;
            state_next = RESP_WAIT;
         end

         RESP_WAIT: begin
            if (resp_sent)
               state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   assign clr_cmd_rdy = clr_reg;
   assign wrt_SPI     = wrt_reg;
   assign send_resp   = send_reg;
   assign SPI_data    = spi_data_reg;
   assign ss          = ss_reg;
   assign resp_data   = resp_reg;
   assign gain        = gain_vec;

endmodule
